// File: rtl/piezo_fire_scheduler_if.sv
// Bundles the control, configuration and drive-status signals of the piezo fire scheduler.
//   master : issues start/abort/event_trigger and configuration, observes drive outputs
//   slave  : the scheduler itself
interface piezo_fire_scheduler_if #(
  parameter int unsigned NUM_CH = 61,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic              event_trigger;
  logic [NUM_CH-1:0] channel_mask;
  logic [7:0]        burst_len;
  logic [CNT_W-1:0]  half_period;
  logic [CNT_W-1:0]  gap_len;
  logic [NUM_CH-1:0] piezo_out;
  logic              piezo_enable;
  logic [2:0]        status;
  logic [5:0]        cur_channel;
  logic              busy;
  logic              done;
  logic              cfg_error;

  modport master (
    output start, abort, event_trigger, channel_mask, burst_len, half_period, gap_len,
    input  piezo_out, piezo_enable, status, cur_channel, busy, done, cfg_error
  );

  modport slave (
    input  start, abort, event_trigger, channel_mask, burst_len, half_period, gap_len,
    output piezo_out, piezo_enable, status, cur_channel, busy, done, cfg_error
  );
endinterface

// File: rtl/piezo_fire_scheduler.sv
// Sequences burst drive waveforms across a masked set of piezo channels in ascending
// order, released by an RTC event trigger, with optional idle gaps between channels.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of piezo_fire_scheduler_if (start/abort/trigger, configuration,
//           piezo_out, piezo_enable, status, cur_channel, busy, done, cfg_error)
// All outputs are registered; status mirrors the state register.
module piezo_fire_scheduler #(
  parameter int unsigned NUM_CH = 61,
  parameter int unsigned CNT_W  = 16
) (
  input logic                  clk,
  input logic                  reset,
  piezo_fire_scheduler_if.slave bus
);

  // Half-period counter must reach 2*255-1.
  localparam int unsigned HP_W = 9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_FIRE = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q;
  logic [7:0]        burst_q;
  logic [CNT_W-1:0]  half_period_q, gap_len_q;
  logic [5:0]        ch_q, ch_d;
  logic [CNT_W-1:0]  half_q, half_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic              phase_q, phase_d;

  logic [NUM_CH-1:0] piezo_out_q, piezo_out_d;
  logic              enable_q, enable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_error_q, cfg_error_d;

  logic [5:0]        first_ch, next_ch;
  logic              has_next;
  logic              start_ok, cfg_ok;
  logic              half_end, hp_last, gap_end;

  // abort outranks start even in IDLE
  assign start_ok = (state_q == S_IDLE) && bus.start && !bus.abort;
  assign cfg_ok   = (bus.channel_mask != '0) && (bus.burst_len != 8'd0) && (bus.half_period != '0);
  assign half_end = (half_q == half_period_q - CNT_W'(1));
  assign hp_last  = (hp_q == ({burst_q, 1'b0} - HP_W'(1)));
  assign gap_end  = (gap_q == gap_len_q - CNT_W'(1));

  // Lowest set channel overall, and lowest set channel strictly above the current one.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask_q[i]) first_ch = 6'(i);
      if (mask_q[i] && (6'(i) > ch_q)) begin
        next_ch  = 6'(i);
        has_next = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    half_d  = half_q;
    hp_d    = hp_q;
    gap_d   = gap_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok && cfg_ok) state_d = S_ARM;
      end
      S_ARM: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.event_trigger) begin
          state_d = S_FIRE;
          ch_d    = first_ch;
          half_d  = '0;
          hp_d    = '0;
          phase_d = 1'b1;
        end
      end
      S_FIRE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          phase_d = 1'b0;
        end else if (!half_end) begin
          half_d = half_q + CNT_W'(1);
        end else if (!hp_last) begin
          half_d  = '0;
          hp_d    = hp_q + HP_W'(1);
          phase_d = ~phase_q;
        end else if (!has_next) begin
          state_d = S_DONE;
          phase_d = 1'b0;
        end else if (gap_len_q != '0) begin
          state_d = S_GAP;
          gap_d   = '0;
          phase_d = 1'b0;
        end else begin
          // back-to-back channels when no gap is configured
          ch_d    = next_ch;
          half_d  = '0;
          hp_d    = '0;
          phase_d = 1'b1;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (gap_end) begin
          state_d = S_FIRE;
          ch_d    = next_ch;
          half_d  = '0;
          hp_d    = '0;
          phase_d = 1'b1;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state; registered below.
  always_comb begin
    piezo_out_d = '0;
    enable_d    = (state_d == S_FIRE) || (state_d == S_GAP);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    cfg_error_d = start_ok && !cfg_ok;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      piezo_out_d[i] = (state_d == S_FIRE) && phase_d && (ch_d == 6'(i));
    end
  end

  // Configuration latch, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q        <= '0;
      burst_q       <= '0;
      half_period_q <= '0;
      gap_len_q     <= '0;
      ch_q          <= '0;
      half_q        <= '0;
      hp_q          <= '0;
      gap_q         <= '0;
      phase_q       <= 1'b0;
      piezo_out_q   <= '0;
      enable_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_error_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        mask_q        <= bus.channel_mask;
        burst_q       <= bus.burst_len;
        half_period_q <= bus.half_period;
        gap_len_q     <= bus.gap_len;
      end
      ch_q        <= ch_d;
      half_q      <= half_d;
      hp_q        <= hp_d;
      gap_q       <= gap_d;
      phase_q     <= phase_d;
      piezo_out_q <= piezo_out_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign bus.piezo_out    = piezo_out_q;
  assign bus.piezo_enable = enable_q;
  assign bus.status       = state_q;
  assign bus.cur_channel  = ch_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cfg_error    = cfg_error_q;

endmodule
